// File: rtl/riscv_biu_pkg.sv
// riscv_biu_pkg
// Shared definitions for the BIU arbiter slice.
//   - arb_state_e : arbiter FSM state (IDLE / ADDR / DATA)
//   - BURST_*     : 3-bit burst type encodings (AHB HBURST style)
//   - type2cnt()  : burst type -> number of data beats minus one
package riscv_biu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_INCR   = 3'd1;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;
  localparam logic [2:0] BURST_INCR4  = 3'd3;
  localparam logic [2:0] BURST_WRAP8  = 3'd4;
  localparam logic [2:0] BURST_INCR8  = 3'd5;
  localparam logic [2:0] BURST_WRAP16 = 3'd6;
  localparam logic [2:0] BURST_INCR16 = 3'd7;

  // Undefined-length INCR is arbitrated as a single beat; the requester
  // re-requests for further beats.
  function automatic logic [3:0] type2cnt(input logic [2:0] burst_type);
    logic [3:0] cnt;
    case (burst_type)
      BURST_WRAP4,  BURST_INCR4:  cnt = 4'd3;
      BURST_WRAP8,  BURST_INCR8:  cnt = 4'd7;
      BURST_WRAP16, BURST_INCR16: cnt = 4'd15;
      default:                    cnt = 4'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/riscv_biu_arbiter_if.sv
// riscv_biu_arbiter_if
// Bundle between the memory units / BIU and the arbiter.
//   req_i, type_i, lock_i               : per-requester request side
//   biu_req_ack_i, biu_ack_i, biu_err_i : BIU responses
//   gnt_o, gnt_idx_o, gnt_vld_o, busy_o, beats_left_o : arbiter results
//
// Handshake: a requester raises req_i[p] and holds it (with a stable
// type_i[p]) until biu_req_ack_i is seen while it owns the grant; that
// edge is the address-phase transfer. Each biu_ack_i then completes one
// data beat; biu_err_i completes the whole transfer immediately.
// Dropping req_i[p] before biu_req_ack_i abandons the request.
interface riscv_biu_arbiter_if #(
  parameter int PORTS = 2
) ();
  localparam int IDXW = $clog2(PORTS);

  logic [PORTS-1:0]       req_i;
  logic [PORTS-1:0][2:0]  type_i;
  logic [PORTS-1:0]       lock_i;
  logic                   biu_req_ack_i;
  logic                   biu_ack_i;
  logic                   biu_err_i;
  logic [PORTS-1:0]       gnt_o;
  logic [IDXW-1:0]        gnt_idx_o;
  logic                   gnt_vld_o;
  logic                   busy_o;
  logic [3:0]             beats_left_o;

  // Arbiter side.
  modport slave (
    input  req_i, type_i, lock_i, biu_req_ack_i, biu_ack_i, biu_err_i,
    output gnt_o, gnt_idx_o, gnt_vld_o, busy_o, beats_left_o
  );

  // Requester / BIU side.
  modport master (
    output req_i, type_i, lock_i, biu_req_ack_i, biu_ack_i, biu_err_i,
    input  gnt_o, gnt_idx_o, gnt_vld_o, busy_o, beats_left_o
  );

endinterface

// File: rtl/riscv_rr_picker.sv
// riscv_rr_picker
// Combinational round-robin pick: searches req upward from ptr, wrapping
// modulo PORTS; the first set bit wins.
//   req    : request vector
//   ptr    : highest-priority index
//   onehot : one-hot winner (0 when nothing requested)
//   idx    : encoded winner (0 when nothing requested)
//   any    : at least one request present
module riscv_rr_picker #(
  parameter int PORTS = 2,
  parameter int IDXW  = $clog2(PORTS)
) (
  input  logic [PORTS-1:0] req,
  input  logic [IDXW-1:0]  ptr,
  output logic [PORTS-1:0] onehot,
  output logic [IDXW-1:0]  idx,
  output logic             any
);

  logic [IDXW-1:0] cand;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    cand   = '0;
    for (int i = 0; i < PORTS; i++) begin
      cand = IDXW'((int'(ptr) + i) % PORTS);
      if (!any && req[cand]) begin
        any          = 1'b1;
        onehot[cand] = 1'b1;
        idx          = cand;
      end
    end
  end

endmodule

// File: rtl/riscv_biu_arbiter.sv
// riscv_biu_arbiter
// Round-robin owner selection for the shared BIU path. A grant is held
// through the address phase and every data beat of its burst, and across
// back-to-back transfers while the owner keeps lock_i asserted.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : riscv_biu_arbiter_if.slave (requests, BIU responses,
//                   grant outputs)
//   dbg_state_o   : current FSM state
//   dbg_rr_ptr_o  : current round-robin priority pointer
module riscv_biu_arbiter
  import riscv_biu_pkg::*;
#(
  parameter int PORTS = 2,
  localparam int IDXW = $clog2(PORTS)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  riscv_biu_arbiter_if.slave   bus,
  output arb_state_e           dbg_state_o,
  output logic [IDXW-1:0]      dbg_rr_ptr_o
);

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] gnt_q, gnt_d;
  logic [IDXW-1:0]  gnt_idx_q, gnt_idx_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic [IDXW-1:0]  rr_ptr_q, rr_ptr_d;

  // Pointer just past the current owner, used whenever ownership ends.
  logic [IDXW-1:0]  ptr_after_gnt;

  logic [PORTS-1:0] idle_onehot, eot_onehot;
  logic [IDXW-1:0]  idle_idx, eot_idx;
  logic             idle_any, eot_any;
  logic             eot;

  assign ptr_after_gnt = (gnt_idx_q == IDXW'(PORTS - 1)) ? '0
                                                         : gnt_idx_q + IDXW'(1);

  riscv_rr_picker #(.PORTS(PORTS), .IDXW(IDXW)) u_pick_idle (
    .req    (bus.req_i),
    .ptr    (rr_ptr_q),
    .onehot (idle_onehot),
    .idx    (idle_idx),
    .any    (idle_any)
  );

  // Re-pick with the already-advanced pointer so a waiting port is granted
  // in the same cycle the previous burst ends (no idle bubble).
  riscv_rr_picker #(.PORTS(PORTS), .IDXW(IDXW)) u_pick_eot (
    .req    (bus.req_i),
    .ptr    (ptr_after_gnt),
    .onehot (eot_onehot),
    .idx    (eot_idx),
    .any    (eot_any)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      gnt_idx_q  <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_idx_q  <= gnt_idx_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_idx_d  = gnt_idx_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    eot        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (idle_any) begin
          state_d   = ST_ADDR;
          gnt_d     = idle_onehot;
          gnt_idx_d = idle_idx;
        end
      end

      ST_ADDR: begin
        // Error wins over a simultaneous address acknowledge.
        if (bus.biu_err_i) begin
          eot = 1'b1;
        end else if (bus.biu_req_ack_i) begin
          state_d    = ST_DATA;
          beat_cnt_d = type2cnt(bus.type_i[gnt_idx_q]);
        end else if (!bus.req_i[gnt_idx_q]) begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
          rr_ptr_d  = ptr_after_gnt;
        end
      end

      ST_DATA: begin
        if (bus.biu_err_i || (bus.biu_ack_i && (beat_cnt_q == 4'd0))) begin
          eot = 1'b1;
        end else if (bus.biu_ack_i) begin
          beat_cnt_d = beat_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        gnt_idx_d = '0;
      end
    endcase

    if (eot) begin
      beat_cnt_d = '0;
      if (bus.lock_i[gnt_idx_q] && bus.req_i[gnt_idx_q]) begin
        // Locked sequence: same owner, same priority pointer.
        state_d = ST_ADDR;
      end else begin
        rr_ptr_d = ptr_after_gnt;
        if (eot_any) begin
          state_d   = ST_ADDR;
          gnt_d     = eot_onehot;
          gnt_idx_d = eot_idx;
        end else begin
          state_d   = ST_IDLE;
          gnt_d     = '0;
          gnt_idx_d = '0;
        end
      end
    end
  end

  assign bus.gnt_o        = gnt_q;
  assign bus.gnt_idx_o    = gnt_idx_q;
  assign bus.gnt_vld_o    = (state_q != ST_IDLE);
  assign bus.busy_o       = (state_q == ST_DATA);
  // beat_cnt_q is cleared on every exit from DATA, so it reads 0 elsewhere.
  assign bus.beats_left_o = beat_cnt_q;

  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
module tb_riscv_biu_arbiter;
  import riscv_biu_pkg::*;

  localparam int NVEC = 28;

  // ---------------- clock / reset ----------------
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk_i = ~clk_i;

  riscv_biu_arbiter_if #(.PORTS(2)) bus ();
  arb_state_e dbg_state;
  logic       dbg_rr_ptr;

  riscv_biu_arbiter #(.PORTS(2)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .bus          (bus),
    .dbg_state_o  (dbg_state),
    .dbg_rr_ptr_o (dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int k,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  task automatic check_outs(input int k, input logic [1:0] gnt, input logic idx,
                            input logic vld, input logic busy,
                            input logic [3:0] beats, input logic ptr);
    check("gnt",   k, 32'(bus.gnt_o),        32'(gnt));
    check("idx",   k, 32'(bus.gnt_idx_o),    32'(idx));
    check("vld",   k, 32'(bus.gnt_vld_o),    32'(vld));
    check("busy",  k, 32'(bus.busy_o),       32'(busy));
    check("beats", k, 32'(bus.beats_left_o), 32'(beats));
    check("rrptr", k, 32'(dbg_rr_ptr),       32'(ptr));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic [1:0] req, input logic [5:0] typ,
                       input logic [1:0] lock, input logic rack,
                       input logic ack, input logic err);
    bus.req_i         = req;
    bus.type_i        = typ;
    bus.lock_i        = lock;
    bus.biu_req_ack_i = rack;
    bus.biu_ack_i     = ack;
    bus.biu_err_i     = err;
  endtask

  // Outputs are registered: sample 1 time unit after the active edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [1:0] req;
    logic [5:0] typ;   // {type port1, type port0}
    logic [1:0] lock;
    logic       rack;
    logic       ack;
    logic       err;
    logic [1:0] gnt;
    logic       idx;
    logic       vld;
    logic       busy;
    logic [3:0] beats;
    logic       ptr;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [1:0] req, input logic [5:0] typ,
                              input logic [1:0] lock, input logic rack,
                              input logic ack, input logic err,
                              input logic [1:0] gnt, input logic idx,
                              input logic vld, input logic busy,
                              input logic [3:0] beats, input logic ptr);
    vec_t v;
    v.req = req; v.typ = typ; v.lock = lock; v.rack = rack; v.ack = ack;
    v.err = err; v.gnt = gnt; v.idx = idx; v.vld = vld; v.busy = busy;
    v.beats = beats; v.ptr = ptr;
    return v;
  endfunction

  initial begin
    //                 req    typ    lock  rk ak er  gnt   ix vl bz beats pt
    // fairness: both request, SINGLE, alternate with no idle cycle
    vecs[0]  = mk(2'b11, 6'o00, 2'b00, 0, 0, 0, 2'b01, 0, 1, 0, 4'd0, 0);
    vecs[1]  = mk(2'b11, 6'o00, 2'b00, 1, 0, 0, 2'b01, 0, 1, 1, 4'd0, 0);
    vecs[2]  = mk(2'b11, 6'o00, 2'b00, 0, 1, 0, 2'b10, 1, 1, 0, 4'd0, 1);
    vecs[3]  = mk(2'b11, 6'o00, 2'b00, 1, 0, 0, 2'b10, 1, 1, 1, 4'd0, 1);
    vecs[4]  = mk(2'b11, 6'o00, 2'b00, 0, 1, 0, 2'b01, 0, 1, 0, 4'd0, 0);
    vecs[5]  = mk(2'b11, 6'o00, 2'b00, 1, 0, 0, 2'b01, 0, 1, 1, 4'd0, 0);
    vecs[6]  = mk(2'b00, 6'o00, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 4'd0, 1);
    // burst hold: port1 WRAP4, port0 requests mid-burst (type0 noise)
    vecs[7]  = mk(2'b10, 6'o20, 2'b00, 0, 0, 0, 2'b10, 1, 1, 0, 4'd0, 1);
    vecs[8]  = mk(2'b10, 6'o20, 2'b00, 1, 0, 0, 2'b10, 1, 1, 1, 4'd3, 1);
    vecs[9]  = mk(2'b01, 6'o27, 2'b00, 0, 1, 0, 2'b10, 1, 1, 1, 4'd2, 1);
    vecs[10] = mk(2'b01, 6'o27, 2'b00, 0, 0, 0, 2'b10, 1, 1, 1, 4'd2, 1);
    vecs[11] = mk(2'b01, 6'o27, 2'b00, 0, 1, 0, 2'b10, 1, 1, 1, 4'd1, 1);
    vecs[12] = mk(2'b01, 6'o27, 2'b00, 0, 1, 0, 2'b10, 1, 1, 1, 4'd0, 1);
    vecs[13] = mk(2'b01, 6'o00, 2'b00, 0, 1, 0, 2'b01, 0, 1, 0, 4'd0, 0);
    // lock: port0 keeps grant for two SINGLEs while port1 waits
    vecs[14] = mk(2'b11, 6'o00, 2'b01, 1, 0, 0, 2'b01, 0, 1, 1, 4'd0, 0);
    vecs[15] = mk(2'b11, 6'o00, 2'b01, 0, 1, 0, 2'b01, 0, 1, 0, 4'd0, 0);
    vecs[16] = mk(2'b11, 6'o00, 2'b01, 1, 0, 0, 2'b01, 0, 1, 1, 4'd0, 0);
    vecs[17] = mk(2'b11, 6'o00, 2'b00, 0, 1, 0, 2'b10, 1, 1, 0, 4'd0, 1);
    // abandon: port1 drops request in ADDR -> IDLE, ptr 0
    vecs[18] = mk(2'b01, 6'o00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 4'd0, 0);
    // error: port0 INCR16, error together with ack on beat 3
    vecs[19] = mk(2'b01, 6'o07, 2'b00, 0, 0, 0, 2'b01, 0, 1, 0, 4'd0, 0);
    vecs[20] = mk(2'b01, 6'o07, 2'b00, 1, 0, 0, 2'b01, 0, 1, 1, 4'd15, 0);
    vecs[21] = mk(2'b00, 6'o07, 2'b00, 0, 1, 0, 2'b01, 0, 1, 1, 4'd14, 0);
    vecs[22] = mk(2'b00, 6'o07, 2'b00, 0, 1, 0, 2'b01, 0, 1, 1, 4'd13, 0);
    vecs[23] = mk(2'b00, 6'o07, 2'b00, 0, 1, 1, 2'b00, 0, 0, 0, 4'd0, 1);
    // responses in IDLE are ignored
    vecs[24] = mk(2'b00, 6'o00, 2'b00, 1, 1, 1, 2'b00, 0, 0, 0, 4'd0, 1);
    // error in ADDR ends transfer; still-requesting port1 regranted
    vecs[25] = mk(2'b10, 6'o00, 2'b00, 0, 0, 0, 2'b10, 1, 1, 0, 4'd0, 1);
    vecs[26] = mk(2'b10, 6'o00, 2'b00, 1, 0, 1, 2'b10, 1, 1, 0, 4'd0, 0);
    vecs[27] = mk(2'b00, 6'o00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 4'd0, 0);
  end

  // ---------------- test sequence ----------------
  initial begin
    drive(2'b00, 6'o00, 2'b00, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    check_outs(100, 2'b00, 0, 0, 0, 4'd0, 0);
    check("state", 100, 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    check_outs(101, 2'b00, 0, 0, 0, 4'd0, 0);

    for (int k = 0; k < NVEC; k++) begin
      drive(vecs[k].req, vecs[k].typ, vecs[k].lock,
            vecs[k].rack, vecs[k].ack, vecs[k].err);
      step();
      check_outs(k, vecs[k].gnt, vecs[k].idx, vecs[k].vld,
                 vecs[k].busy, vecs[k].beats, vecs[k].ptr);
    end

    // Reset mid-burst: port0 INCR8, two beats done -> beats_left 5.
    drive(2'b01, 6'o05, 2'b00, 0, 0, 0);
    step();
    check_outs(200, 2'b01, 0, 1, 0, 4'd0, 0);
    drive(2'b01, 6'o05, 2'b00, 1, 0, 0);
    step();
    check_outs(201, 2'b01, 0, 1, 1, 4'd7, 0);
    drive(2'b00, 6'o05, 2'b00, 0, 1, 0);
    step();
    step();
    check_outs(202, 2'b01, 0, 1, 1, 4'd5, 0);
    drive(2'b00, 6'o00, 2'b00, 0, 0, 0);
    #2 rst_ni = 1'b0;
    #1;
    // Asynchronous: outputs clear without any clock edge.
    check_outs(203, 2'b00, 0, 0, 0, 4'd0, 0);
    check("state", 203, 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk_i) rst_ni = 1'b1;
    step();
    step();
    check_outs(204, 2'b00, 0, 0, 0, 4'd0, 0);
    check("state", 204, 32'(dbg_state), 32'(ST_IDLE));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
